mult8_seq_ctrl: RTL

Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing a single combinational 4x4 array multiplier core (4b x 4b -> 8b) over four cycles. It accepts operands over a valid/ready handshake and slices them into nibbles. It accumulates the shifted partial products in a 16-bit register and presents the result over a second valid/ready handshake. It sits between the tile's operand registers and the result output path, and lets the existing area-cheap 4x4 datapath serve 8-bit multiplies.

---
 rtl/mult8_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over one shared 4x4 array core
// Four nibble partial products are accumulated over four cycles, then handed off via valid/ready.

module mult4x4_core (
    input  logic [3:0] m,
    input  logic [3:0] q,
    output logic [7:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (q[i]) begin
                p = p + ({4'b0000, m} << i);
            end
        end
    end
endmodule

module mult8_seq_ctrl #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic [7:0]  op_count
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc;
    logic [1:0]  step;
    logic [3:0]  m_nib, q_nib;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    // step[0] picks the multiplicand nibble, step[1] the multiplier nibble
    assign m_nib = step[0] ? a_q[7:4] : a_q[3:0];
    assign q_nib = step[1] ? b_q[7:4] : b_q[3:0];

    mult4x4_core u_core (
        .m (m_nib),
        .q (q_nib),
        .p (pp)
    );

    always_comb begin
        pp_shifted = {pp, 8'h00};
        case (step)
            2'd0:       pp_shifted = {8'h00, pp};
            2'd1, 2'd2: pp_shifted = {4'h0, pp, 4'h0};
            default:    pp_shifted = {pp, 8'h00};
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_n = (EARLY_ZERO && (a == 8'h00 || b == 8'h00)) ? DONE : MUL;
                end
            end
            MUL: begin
                if (step == 2'd3) state_n = DONE;
            end
            DONE: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            step     <= '0;
            op_count <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                end
                DONE: begin
                    if (res_ready) op_count <= op_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign result      = acc;
endmodule
